// File: rtl/radiance_recovery.sv
// -----------------------------------------------------------------------------
// radiance_recovery
//
// Scene-radiance recovery: per RGB channel J = (I - A) * tran_inv + A, rounded
// to nearest (ties toward +inf) and clamped to DATA_W bits. The hazy pixel I is
// delayed LAT cycles so it meets the tran_inv computed for it upstream.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a_load, a_r/a_g/a_b      atmospheric light A, captured when a_load=1
//   pix_valid_in, pix_r/g/b  hazy pixel I
//   tran_valid_in, tran_inv  inverse transmission, unsigned Q4.8 (0 = undefined)
//   out_valid, out_r/g/b     recovered pixel J (registered, held when idle)
//   align_err                sticky pixel/transmission misalignment flag
//
// Pipeline after pairing: s1 (d = I - A), s2 (p = d * tran_inv),
// s3 (s = round(p) + A), output register (clamp / bypass).
// -----------------------------------------------------------------------------
module radiance_recovery #(
   parameter int DATA_W    = 8,
   parameter int TINV_W    = 12,
   parameter int TINV_FRAC = 8,
   parameter int LAT       = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_load,
   input  logic [DATA_W-1:0] a_r,
   input  logic [DATA_W-1:0] a_g,
   input  logic [DATA_W-1:0] a_b,
   input  logic              pix_valid_in,
   input  logic [DATA_W-1:0] pix_r,
   input  logic [DATA_W-1:0] pix_g,
   input  logic [DATA_W-1:0] pix_b,
   input  logic              tran_valid_in,
   input  logic [TINV_W-1:0] tran_inv,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_r,
   output logic [DATA_W-1:0] out_g,
   output logic [DATA_W-1:0] out_b,
   output logic              align_err
);

   localparam int PIX_W = 3 * DATA_W;
   localparam int D_W   = DATA_W + 1;            // signed I - A
   localparam int P_W   = D_W + TINV_W + 1;      // signed d * tran_inv, no overflow
   localparam int S_W   = P_W - TINV_FRAC + 1;   // rounded product plus A
   localparam logic signed [P_W-1:0] ROUND = P_W'(1 << (TINV_FRAC - 1));
   localparam logic signed [S_W-1:0] MAX_S = S_W'((1 << DATA_W) - 1);

   // Channel words are packed {r, g, b}; channel gi occupies [gi*DATA_W +: DATA_W].
   logic [PIX_W-1:0] a_reg;
   logic [PIX_W-1:0] dl_pix_reg [LAT];
   logic [LAT-1:0]   dl_valid_reg;

   logic             tail_valid;
   logic [PIX_W-1:0] tail_pix;
   logic             pair;

   logic              s1_valid_reg, s2_valid_reg, s3_valid_reg;
   logic              s1_bypass_reg, s2_bypass_reg, s3_bypass_reg;
   logic [TINV_W-1:0] s1_tinv_reg;
   logic [PIX_W-1:0]  s1_pix_reg, s2_pix_reg, s3_pix_reg;
   logic [PIX_W-1:0]  s1_a_reg, s2_a_reg;
   logic [PIX_W-1:0]  j_word;
   logic [PIX_W-1:0]  out_word_reg;
   logic              out_valid_reg;
   logic              align_err_reg;

   assign tail_valid = dl_valid_reg[LAT-1];
   assign tail_pix   = dl_pix_reg[LAT-1];
   assign pair       = tran_valid_in & tail_valid;

   // Atmospheric light. A stage-1 capture on the same edge sees the old value.
   always_ff @(posedge clk) begin
      if (rst)
         a_reg <= '1;
      else if (a_load)
         a_reg <= {a_r, a_g, a_b};
   end

   // Free-running pixel delay line; only the valid bits are reset.
   always_ff @(posedge clk) begin
      dl_pix_reg[0] <= {pix_r, pix_g, pix_b};
      for (int i = 1; i < LAT; i++)
         dl_pix_reg[i] <= dl_pix_reg[i-1];
      if (rst) begin
         dl_valid_reg <= '0;
      end else begin
         dl_valid_reg[0] <= pix_valid_in;
         for (int i = 1; i < LAT; i++)
            dl_valid_reg[i] <= dl_valid_reg[i-1];
      end
   end

   // Control path plus the channel-shared carried data (I, A copy, bypass).
   always_ff @(posedge clk) begin
      s1_bypass_reg <= (tran_inv == '0);
      s1_tinv_reg   <= tran_inv;
      s1_pix_reg    <= tail_pix;
      s1_a_reg      <= a_reg;
      s2_bypass_reg <= s1_bypass_reg;
      s2_pix_reg    <= s1_pix_reg;
      s2_a_reg      <= s1_a_reg;
      s3_bypass_reg <= s2_bypass_reg;
      s3_pix_reg    <= s2_pix_reg;
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s2_valid_reg  <= 1'b0;
         s3_valid_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_word_reg  <= '0;
         align_err_reg <= 1'b0;
      end else begin
         s1_valid_reg  <= pair;
         s2_valid_reg  <= s1_valid_reg;
         s3_valid_reg  <= s2_valid_reg;
         out_valid_reg <= s3_valid_reg;
         if (s3_valid_reg)
            out_word_reg <= j_word;
         // A lone pixel or lone tran_inv is dropped and latches the error.
         if (tran_valid_in ^ tail_valid)
            align_err_reg <= 1'b1;
      end
   end

   // Per-channel arithmetic.
   for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic signed [D_W-1:0] s1_d_reg;
      logic signed [P_W-1:0] s2_p_reg;
      logic signed [S_W-1:0] s3_s_reg;

      always_ff @(posedge clk) begin
         s1_d_reg <= $signed({1'b0, tail_pix[gi*DATA_W +: DATA_W]})
                   - $signed({1'b0, a_reg[gi*DATA_W +: DATA_W]});
         s2_p_reg <= P_W'(s1_d_reg) * P_W'($signed({1'b0, s1_tinv_reg}));
         // Arithmetic shift gives floor((p + half) / 2^FRAC).
         s3_s_reg <= S_W'((s2_p_reg + ROUND) >>> TINV_FRAC)
                   + S_W'($signed({1'b0, s2_a_reg[gi*DATA_W +: DATA_W]}));
      end

      assign j_word[gi*DATA_W +: DATA_W] =
         s3_bypass_reg       ? s3_pix_reg[gi*DATA_W +: DATA_W] :
         s3_s_reg[S_W-1]     ? {DATA_W{1'b0}} :
         (s3_s_reg > MAX_S)  ? {DATA_W{1'b1}} :
                               s3_s_reg[DATA_W-1:0];
   end

   assign out_valid = out_valid_reg;
   assign out_r     = out_word_reg[2*DATA_W +: DATA_W];
   assign out_g     = out_word_reg[DATA_W +: DATA_W];
   assign out_b     = out_word_reg[0 +: DATA_W];
   assign align_err = align_err_reg;

endmodule

// File: tb/tb_radiance_recovery.sv
// -----------------------------------------------------------------------------
// tb_radiance_recovery: directed bench for radiance_recovery (LAT = 3).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_radiance_recovery;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_load;
   logic [7:0]  a_r, a_g, a_b;
   logic        pix_valid_in;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic        tran_valid_in;
   logic [11:0] tran_inv;
   logic        out_valid;
   logic [7:0]  out_r, out_g, out_b;
   logic        align_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   radiance_recovery #(
      .DATA_W(8), .TINV_W(12), .TINV_FRAC(8), .LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst), .a_load(a_load),
      .a_r(a_r), .a_g(a_g), .a_b(a_b),
      .pix_valid_in(pix_valid_in), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .tran_valid_in(tran_valid_in), .tran_inv(tran_inv),
      .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b),
      .align_err(align_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [23:0] a);
      a_load = 1'b1;
      {a_r, a_g, a_b} = a;
      step();
      a_load = 1'b0;
   endtask

   // One pixel, paired LAT cycles later; returns J and edges from the
   // tran_valid_in edge to out_valid (10 if it never came).
   task automatic one_pixel(input logic [23:0] pix, input logic [11:0] ti,
                            output logic [23:0] res, output int lat);
      pix_valid_in = 1'b1;
      {pix_r, pix_g, pix_b} = pix;
      step();
      pix_valid_in = 1'b0;
      repeat (LAT - 1) step();
      tran_valid_in = 1'b1;
      tran_inv = ti;
      step();
      tran_valid_in = 1'b0;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!out_valid && lat < 10);
      res = {out_r, out_g, out_b};
      $display("[TB] pixel I=%h tinv=%0d -> J=%h valid=%0b after %0d cycles",
               pix, ti, res, out_valid, lat);
   endtask

   task automatic test_reset();
      logic [23:0] res;
      int lat;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_tests++;
      if ({out_r, out_g, out_b} !== 24'h0) begin n_fail++; $display("FAIL reset_out got %h want 000000", {out_r, out_g, out_b}); end
      n_tests++;
      if (align_err !== 1'b0) begin n_fail++; $display("FAIL reset_align got %b want 0", align_err); end
      // Default A = 255: I=(250,200,255), tinv=512 -> (245,145,255)
      one_pixel({8'd250, 8'd200, 8'd255}, 12'd512, res, lat);
      n_tests++;
      if (res !== 24'hf591ff) begin n_fail++; $display("FAIL reset_a255 got %h want f591ff", res); end
   endtask

   task automatic test_basic();
      logic [23:0] res;
      logic [23:0] held;
      int lat;
      load_a({8'd200, 8'd200, 8'd200});
      one_pixel({8'd150, 8'd150, 8'd150}, 12'd384, res, lat);
      n_tests++;
      if (res !== 24'h7d7d7d) begin n_fail++; $display("FAIL basic_j got %h want 7d7d7d", res); end
      n_tests++;
      if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", lat); end
      held = res;
      step();
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %b want 0", out_valid); end
      n_tests++;
      if ({out_r, out_g, out_b} !== held) begin n_fail++; $display("FAIL basic_hold got %h want %h", {out_r, out_g, out_b}, held); end
   endtask

   task automatic test_clamp();
      logic [23:0] res;
      int lat;
      load_a({8'd200, 8'd200, 8'd200});
      one_pixel({8'd100, 8'd100, 8'd100}, 12'd512, res, lat);
      n_tests++;
      if (res !== 24'h000000) begin n_fail++; $display("FAIL clamp_low got %h want 000000", res); end
      one_pixel({8'd250, 8'd250, 8'd250}, 12'd1024, res, lat);
      n_tests++;
      if (res !== 24'hffffff) begin n_fail++; $display("FAIL clamp_high got %h want ffffff", res); end
      // Mixed channels at A=200, tinv=384: (150,220,100) -> (125,230,50)
      one_pixel({8'd150, 8'd220, 8'd100}, 12'd384, res, lat);
      n_tests++;
      if (res !== 24'h7de632) begin n_fail++; $display("FAIL mixed_round got %h want 7de632", res); end
   endtask

   task automatic test_identity();
      logic [23:0] res;
      int lat;
      load_a({8'd250, 8'd3, 8'd128});
      one_pixel({8'd17, 8'd99, 8'd231}, 12'd256, res, lat);
      n_tests++;
      if (res !== {8'd17, 8'd99, 8'd231}) begin n_fail++; $display("FAIL identity got %h want %h", res, {8'd17, 8'd99, 8'd231}); end
      load_a({8'd200, 8'd200, 8'd200});
      one_pixel({8'd37, 8'd37, 8'd37}, 12'd0, res, lat);
      n_tests++;
      if (res !== 24'h252525) begin n_fail++; $display("FAIL bypass got %h want 252525", res); end
   endtask

   task automatic test_bounds();
      logic [23:0] res;
      int lat;
      // tinv=4095: d=-255 -> 0, d=+255 -> 255, d=+1 -> 16+200 = 216
      load_a({8'd255, 8'd0, 8'd200});
      one_pixel({8'd0, 8'd255, 8'd201}, 12'd4095, res, lat);
      n_tests++;
      if (res !== 24'h00ffd8) begin n_fail++; $display("FAIL tinv_max got %h want 00ffd8", res); end
      load_a({8'd77, 8'd77, 8'd77});
      one_pixel({8'd77, 8'd77, 8'd77}, 12'd999, res, lat);
      n_tests++;
      if (res !== 24'h4d4d4d) begin n_fail++; $display("FAIL i_eq_a got %h want 4d4d4d", res); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] exp_j;
      load_a({8'd200, 8'd200, 8'd200});
      for (int t = 0; t < LAT + 16; t++) begin
         pix_valid_in  = (t < 10);
         {pix_r, pix_g, pix_b} = {8'd150, 8'd220, 8'd100};
         tran_valid_in = (t >= LAT) && (t < LAT + 10);
         tran_inv      = 12'd384;
         a_load        = (t == LAT + 5);   // pixel 5's stage-1 edge
         {a_r, a_g, a_b} = {8'd100, 8'd100, 8'd100};
         step();
         if (t >= LAT + 3 && t < LAT + 13) begin
            exp_j = (t - LAT - 3 <= 5) ? 24'h7de632 : 24'haf_ff_64;
            $display("[TB] stream pixel %0d J=%h valid=%0b", t - LAT - 3, {out_r, out_g, out_b}, out_valid);
            n_tests++;
            if (out_valid !== 1'b1 || {out_r, out_g, out_b} !== exp_j) begin
               n_fail++;
               $display("FAIL stream_pix%0d got v=%b %h want v=1 %h", t - LAT - 3, out_valid, {out_r, out_g, out_b}, exp_j);
            end
         end else begin
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle_t%0d got %b want 0", t, out_valid); end
         end
      end
      pix_valid_in = 1'b0;
      tran_valid_in = 1'b0;
      a_load = 1'b0;
      n_tests++;
      if (align_err !== 1'b0) begin n_fail++; $display("FAIL stream_align got %b want 0", align_err); end
   endtask

   task automatic test_misalign();
      logic [23:0] res;
      int lat;
      int seen;
      load_a({8'd200, 8'd200, 8'd200});
      tran_valid_in = 1'b1;
      tran_inv = 12'd384;
      step();
      tran_valid_in = 1'b0;
      n_tests++;
      if (align_err !== 1'b1) begin n_fail++; $display("FAIL misalign_flag got %b want 1", align_err); end
      seen = 0;
      repeat (6) begin step(); if (out_valid) seen++; end
      $display("[TB] lone tran_inv: outputs seen %0d", seen);
      n_tests++;
      if (seen !== 0) begin n_fail++; $display("FAIL misalign_drop got %0d outputs want 0", seen); end
      one_pixel({8'd150, 8'd220, 8'd100}, 12'd384, res, lat);
      n_tests++;
      if (res !== 24'h7de632) begin n_fail++; $display("FAIL misalign_after got %h want 7de632", res); end
      // Lone pixel with no tran_inv is dropped too.
      pix_valid_in = 1'b1;
      step();
      pix_valid_in = 1'b0;
      seen = 0;
      repeat (LAT + 6) begin step(); if (out_valid) seen++; end
      $display("[TB] lone pixel: outputs seen %0d", seen);
      n_tests++;
      if (seen !== 0) begin n_fail++; $display("FAIL lone_pix_drop got %0d outputs want 0", seen); end
      n_tests++;
      if (align_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky got %b want 1", align_err); end
   endtask

   task automatic test_reset_mid();
      logic [23:0] res;
      int lat;
      int seen;
      load_a({8'd200, 8'd200, 8'd200});
      for (int t = 0; t <= LAT + 1; t++) begin
         pix_valid_in  = (t < 3);
         {pix_r, pix_g, pix_b} = {8'd150, 8'd150, 8'd150};
         tran_valid_in = (t >= LAT);
         tran_inv      = 12'd384;
         rst           = (t == LAT + 1);
         step();
      end
      rst = 1'b0;
      pix_valid_in = 1'b0;
      tran_valid_in = 1'b0;
      seen = 0;
      repeat (6) begin step(); if (out_valid) seen++; end
      $display("[TB] reset mid-stream: outputs seen %0d", seen);
      n_tests++;
      if (seen !== 0) begin n_fail++; $display("FAIL rstmid_drop got %0d outputs want 0", seen); end
      n_tests++;
      if ({out_r, out_g, out_b} !== 24'h0) begin n_fail++; $display("FAIL rstmid_out got %h want 000000", {out_r, out_g, out_b}); end
      n_tests++;
      if (align_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_align got %b want 0", align_err); end
      one_pixel({8'd250, 8'd200, 8'd255}, 12'd512, res, lat);
      n_tests++;
      if (res !== 24'hf591ff) begin n_fail++; $display("FAIL rstmid_after got %h want f591ff", res); end
      n_tests++;
      if (lat !== 3) begin n_fail++; $display("FAIL rstmid_latency got %0d want 3", lat); end
   endtask

   initial begin
      rst = 1'b1;
      a_load = 1'b0;
      {a_r, a_g, a_b} = '0;
      pix_valid_in = 1'b0;
      {pix_r, pix_g, pix_b} = '0;
      tran_valid_in = 1'b0;
      tran_inv = '0;
      test_reset();
      test_basic();
      test_clamp();
      test_identity();
      test_bounds();
      test_back_to_back();
      test_misalign();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/radiance_recovery.md
# radiance_recovery

Scene-radiance recovery stage. It sits directly downstream of the transmission-map stage and consumes its 12-bit inverse transmission `tran_inv`. Per RGB channel it computes J = (I − A)·tran_inv + A, rounds the result and clamps it to 8 bits. The hazy input pixel is delayed internally so that it lines up with the `tran_inv` value that arrives later for it.

## Interface
- `DATA_W`, 8: pixel/channel width.
- `TINV_W`, 12: width of `tran_inv`.
- `TINV_FRAC`, 8: fractional bits of `tran_inv` (Q4.8, 256 = 1.0).
- `LAT`, 3: cycles from a pixel on `pix_valid_in` to its `tran_inv` on `tran_valid_in`; range 1–15.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_load`  in  1  capture atmospheric light on this edge.
- `a_r`, `a_g`, `a_b`  in  8 each  atmospheric light A per channel.
- `pix_valid_in`  in  1  hazy pixel present.
- `pix_r`, `pix_g`, `pix_b`  in  8 each  hazy pixel I.
- `tran_valid_in`  in  1  `tran_inv` present.
- `tran_inv`  in  12  1/t, unsigned Q4.8; 0 means undefined.
- `out_valid`  out  1  recovered pixel present.
- `out_r`, `out_g`, `out_b`  out  8 each  recovered pixel J.
- `align_err`  out  1  sticky pixel/transmission misalignment flag.

## Operation
- **A register:** on an edge with `a_load`=1, A ← {`a_r`, `a_g`, `a_b`}. Reset value is 255/255/255.
- **Delay line:** `LAT`-deep shift register of {valid, I}. It advances every cycle with no stall and no backpressure.
- **Pairing:** a pair forms when `tran_valid_in`=1 and the delay-line tail valid=1. That pair enters stage 1.
- **Misalignment:** when exactly one of `tran_valid_in` and tail-valid is 1:
  - the lone item is dropped (no output for it);
  - `align_err` ← 1 and stays 1 until `rst`.
- **Stage 1 (per channel):**
  - d = I − A, signed 9-bit in [−255, 255];
  - register d, `tran_inv`, and a copy of A;
  - flag `bypass` = (`tran_inv` == 0).
- **Stage 2:** p = d × `tran_inv`, signed 22-bit. The carried A, I and `bypass` follow the data.
- **Stage 3:**
  - q = (p + 128) >>> 8, arithmetic shift, i.e. floor((p + 128)/256);
  - s = q + A_carried, signed;
  - J = 0 if s < 0, 255 if s > 255, otherwise s;
  - if `bypass`=1, J = I unchanged.
- **A during a load:** the A copy travels with each pixel. A mid-stream `a_load` never mixes the old and new A inside one pixel.
- **Outputs:** `out_*` and `out_valid` are registered. `out_*` holds its last value while `out_valid`=0.

## Timing
- **Latency:** `out_valid` asserts 3 cycles after the paired `tran_valid_in` edge, i.e. `LAT`+3 cycles after `pix_valid_in`.
- **Throughput:** one pixel per cycle, sustained.
- **a_load vs. stage 1:** when `a_load` and a stage-1 capture fall on the same edge, stage 1 uses the old A. The new A applies from the next edge.
- **Reset values:**
  - `out_valid`=0;
  - `out_r/g/b`=0;
  - `align_err`=0;
  - every delay-line and pipeline valid bit = 0;
  - A=255.
- **Reset mid-stream:** in-flight pixels are discarded, with no output for them. The first valid pair after `rst` deasserts behaves as in a fresh start.
- **Bounds:**
  - `tran_inv`=256 gives J=I exactly for any A;
  - `tran_inv`=4095 with |d|=255 must not overflow p;
  - I=A gives J=A for any `tran_inv`.

## Test plan
1. **Basic pixel:** A=200, I=150, `tran_inv`=384 (1.5), paired correctly → J=125 on all channels, `out_valid` exactly 3 cycles after `tran_valid_in`.
2. **Clamps and rounding tie:**
   - A=200, I=100, `tran_inv`=512 → J=0 (clamp low; −199.5 floors to −200);
   - A=200, I=250, `tran_inv`=1024 → s=400, J=255.
3. **Identity and bypass:**
   - `tran_inv`=256 with random I/A → J=I;
   - `tran_inv`=0 with I=37, A=200 → J=37.
4. **Mid-stream A load:** back-to-back stream of 10 pixels with `a_load` (A 200→100) coincident with pixel 5's stage-1 edge → pixels 0–5 use A=200, pixels 6–9 use A=100, no gaps in `out_valid`.
5. **Misalignment:** extra `tran_valid_in` pulse with no pixel → pulse dropped, `align_err`=1 and held; following correctly paired pixels still produce correct J.
6. **Reset mid-stream:** `rst` one cycle while 3 pixels are in flight → no outputs for them, `out_*`=0, A=255, `align_err`=0; the next pair yields the correct J after 3 cycles.
